// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned UART_DATA_W = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last cycle.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            en,
    output logic                            tick,
    output logic [$clog2(CLKS_PER_BIT)-1:0] cnt
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);
    assign cnt  = cnt_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the TX FIFO and serializes each as an 8N1 UART frame.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(CLKS_PER_BIT - 2);

    tx_state_t              state_d, state_q;
    logic [UART_DATA_W-1:0] shift_d, shift_q;
    logic [2:0]             bit_idx_d, bit_idx_q;
    logic                   tx_d, tx_q;
    logic                   fifo_rd_d, fifo_rd_q;
    logic                   busy_d, busy_q;
    logic                   done_d, done_q;

    logic                   baud_clr;
    logic                   baud_en;
    logic                   baud_tick;
    logic [CNT_W-1:0]       baud_cnt;

    // Counter restarts on every state entry and only runs in the timed states.
    assign baud_clr = (state_d != state_q);
    assign baud_en  = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (baud_clr),
        .en   (baud_en),
        .tick (baud_tick),
        .cnt  (baud_cnt)
    );

    // Next-state and registered-output logic; outputs are computed for the next cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;
        fifo_rd_d = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = STOP_BIT;
                if (en && !fifo_empty) begin
                    state_d   = POP;
                    fifo_rd_d = 1'b1;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = fifo_dout;
                tx_d    = START_BIT;
                state_d = START;
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = STOP_BIT;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                done_d = (baud_cnt == DONE_CNT);
                if (baud_tick) begin
                    if (en && !fifo_empty) begin
                        state_d   = POP;
                        fifo_rd_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = STOP_BIT;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= STOP_BIT;
            fifo_rd_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
            fifo_rd_q <= fifo_rd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx      = tx_q;
    assign fifo_rd = fifo_rd_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: frame-timeline reference model plus directed and random stimulus.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int T_END = 2 + 10 * CPB;  // frame-relative index of the final stop cycle

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         m_ptr  = 0;
    logic       force_empty;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_rd     = 0;

    // Reference model: frame position t counts cycles since the pop decision edge.
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_byte   = 8'h00;
    logic       rd_prev  = 1'b0;

    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd   (fifo_rd),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    function automatic logic exp_tx(input int t, input logic [7:0] b);
        int k;
        if (t < 3) return 1'b1;
        k = (t - 3) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // One clock: advance model at the edge, serve the FIFO and compare just after, return at the negedge.
    task automatic tick();
        logic e_tx, e_rd, e_busy, e_done;
        @(posedge clk);
        if (!rst_n) begin
            m_active = 1'b0;
        end else if (m_active && m_t < T_END) begin
            m_t++;
        end else if (en && !fifo_empty) begin
            m_active = 1'b1;
            m_t      = 1;
            m_byte   = mem[m_ptr];
            m_ptr++;
        end else begin
            m_active = 1'b0;
        end
        #1;
        if (!rst_n) rd_prev = 1'b0;
        if (rd_prev && rd_ptr < wr_ptr) begin
            fifo_dout = mem[rd_ptr];
            rd_ptr++;
        end
        e_tx   = m_active ? exp_tx(m_t, m_byte) : 1'b1;
        e_rd   = m_active && (m_t == 1);
        e_busy = m_active;
        e_done = m_active && (m_t == T_END);
        chk("tx", tx, e_tx);
        chk("fifo_rd", fifo_rd, e_rd);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (fifo_rd) n_rd++;
        rd_prev = fifo_rd;
        @(negedge clk);
    endtask

    initial begin
        int         n0, c, lo, hi, cy;
        logic [9:0] a5_frame;

        rst_n       = 1'b0;
        en          = 1'b1;
        force_empty = 1'b0;
        fifo_dout   = 8'h00;

        // Reset held with data waiting and enable high: line must stay idle.
        push(8'hA5);
        repeat (6) tick();
        rst_n = 1'b1;

        // Single frame 0xA5 with literal timing.
        n0 = n_rd;
        c  = 0;
        while (!fifo_rd && c < 20) begin tick(); c++; end
        chk("a5_rd_seen", fifo_rd, 1);
        c = 0;
        while (tx && c < 20) begin tick(); c++; end
        chk("a5_rd_to_fall", c, 2);
        a5_frame = 10'b11010_01010;  // stop, d7..d0 of 0xA5, start (LSB sent first)
        for (int b = 0; b < 10; b++) begin
            chk("a5_bit", tx, a5_frame[b]);
            if (b < 9) repeat (CPB) tick();
        end
        cy = 37;
        while (!done && cy < 60) begin tick(); cy++; end
        chk("a5_done_cycle", cy, 40);
        tick();
        chk("a5_busy_after", busy, 0);
        chk("a5_rd_count", n_rd - n0, 1);

        // Back-to-back 0x00 then 0xFF.
        repeat (3) tick();
        n0 = n_rd;
        push(8'h00);
        push(8'hFF);
        c = 0;
        while (tx && c < 20) begin tick(); c++; end
        lo = 0;
        while (!tx && lo < 100) begin tick(); lo++; end
        chk("b2b_f1_low", lo, 9 * CPB);
        hi = 0;
        while (tx && hi < 100) begin tick(); hi++; end
        chk("b2b_stop_high", hi, CPB + 2);
        lo = 0;
        while (!tx && lo < 100) begin tick(); lo++; end
        chk("b2b_f2_start_low", lo, CPB);
        hi = 0;
        while (tx && busy && hi < 100) begin tick(); hi++; end
        chk("b2b_f2_high", hi, 9 * CPB);
        repeat (3) tick();
        chk("b2b_rd_count", n_rd - n0, 2);
        chk("b2b_idle", busy, 0);

        // Enable gating: no pop while disabled, and drop enable mid-frame.
        en = 1'b0;
        n0 = n_rd;
        push(8'h3C);
        push(8'hC3);
        repeat (100) tick();
        chk("en0_no_rd", n_rd - n0, 0);
        en = 1'b1;
        c  = 0;
        while (tx && c < 20) begin tick(); c++; end
        repeat (4 * CPB) tick();
        en = 1'b0;
        c  = 0;
        while (!done && c < 60) begin tick(); c++; end
        chk("gate_done", done, 1);
        repeat (50) tick();
        chk("gate_rd_count", n_rd - n0, 1);

        // Reset during data bit 5 of 0xC3 (bit value 0).
        n0 = n_rd;
        en = 1'b1;
        c  = 0;
        while (tx && c < 20) begin tick(); c++; end
        repeat (6 * CPB) tick();
        chk("pre_rst_tx", tx, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_tx_async", tx, 1);
        chk("rst_busy_async", busy, 0);
        chk("rst_rd_async", fifo_rd, 0);
        push(8'h5A);
        repeat (3) tick();
        rst_n = 1'b1;
        c = 0;
        while (!fifo_rd && c < 20) begin tick(); c++; end
        chk("rst_new_pop", fifo_rd, 1);
        c = 0;
        while (!done && c < 60) begin tick(); c++; end
        repeat (5) tick();
        chk("rst_rd_count", n_rd - n0, 2);

        // Empty FIFO forever, then data arriving exactly in the final stop cycle.
        n0 = n_rd;
        repeat (60) tick();
        chk("empty_no_rd", n_rd - n0, 0);
        chk("empty_tx_idle", tx, 1);
        push(8'h96);
        c = 0;
        while (!done && c < 100) begin tick(); c++; end
        chk("empty_done_seen", done, 1);
        push(8'h69);
        tick();
        chk("empty_fall_pop", fifo_rd, 1);
        chk("empty_fall_busy", busy, 1);
        c = 0;
        while (!done && c < 100) begin tick(); c++; end
        repeat (5) tick();

        // Randomized traffic with occasional enable toggles.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0 && (wr_ptr - rd_ptr) < 4 && wr_ptr < 1000)
                push(8'($urandom));
            if ($urandom_range(0, 49) == 0) en = ~en;
            tick();
        end
        en = 1'b1;
        repeat (300) tick();
        chk("drain_empty", wr_ptr - rd_ptr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
